alu_result_fifo: RTL and testbench

- Downstream buffering stage for the 8-bit three-operand adder/ALU.
- Captures each result word R, its carry-out and the opcode that produced it into a small synchronous FIFO.
- Presents entries to the next consumer over a valid/ready handshake, with a per-entry zero flag and a saturating count of carry events.
- Decouples the combinational ALU from a consumer that may stall.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_sat_counter.sv | 31 +++
 rtl/alu_result_fifo.sv | 119 +++++++++++
 tb/tb_alu_result_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the three-operand adder/ALU and its result buffer.
// Opcode encodings and the packed result-entry layout live here.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OPC_W  = 2;

    localparam logic [OPC_W-1:0] ALU_OP_ADD  = 2'd0;
    localparam logic [OPC_W-1:0] ALU_OP_ADDC = 2'd1;
    localparam logic [OPC_W-1:0] ALU_OP_SUB  = 2'd2;
    localparam logic [OPC_W-1:0] ALU_OP_PASS = 2'd3;

    typedef struct packed {
        logic              cout;
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] r;
    } alu_entry_t;

    localparam int ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module alu_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != {CNT_W{1'b1}})) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/alu_result_fifo.sv
// Small synchronous FIFO buffering ALU results (R, carry, opcode) toward a
// consumer over valid/ready, with a zero flag and a saturating carry counter.
module alu_result_fifo #(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 2,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_r,
    input  logic                     in_cout,
    input  logic [OPC_W-1:0]         in_opcode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_r,
    output logic                     out_cout,
    output logic [OPC_W-1:0]         out_opcode,
    output logic                     out_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         carry_cnt
);

    import alu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    typedef struct packed {
        logic              cout;
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] r;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           head;

    // Handshake qualifiers depend only on registered occupancy, so in_ready
    // never sees out_ready combinationally; rst masks both.
    always_comb begin
        in_ready  = (count_q != FULL_CNT);
        out_valid = (count_q != '0);
        push      = in_valid && in_ready && !rst;
        pop       = out_valid && out_ready && !rst;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        wr_entry        = '0;
        wr_entry.cout   = in_cout;
        wr_entry.opcode = in_opcode;
        wr_entry.r      = in_r;
    end

    // Storage is deliberately left unreset; the occupancy counter gates
    // whether any slot is observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        out_r      = out_valid ? head.r      : '0;
        out_cout   = out_valid ? head.cout   : 1'b0;
        out_opcode = out_valid ? head.opcode : '0;
        out_zero   = out_valid && (head.r == '0);
    end

    assign count = count_q;

    alu_sat_counter #(
        .CNT_W (CNT_W)
    ) u_carry_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (push && in_cout),
        .value (carry_cnt)
    );

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based model.
module tb_alu_result_fifo;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_cout;
    logic [7:0] in_r;
    logic [1:0] in_opcode;
    logic       out_ready;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [7:0] out_r,     out_r2;
    logic       out_cout,  out_cout2;
    logic [1:0] out_opcode, out_opcode2;
    logic       out_zero,  out_zero2;
    logic [2:0] count,     count2;
    logic [7:0] carry_cnt;
    logic [1:0] carry_cnt2;

    always #5 clk = ~clk;

    alu_result_fifo #(.DATA_W(8), .OPC_W(2), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_cout(in_cout), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
        .out_cout(out_cout), .out_opcode(out_opcode), .out_zero(out_zero),
        .count(count), .carry_cnt(carry_cnt)
    );

    alu_result_fifo #(.DATA_W(8), .OPC_W(2), .DEPTH(DEPTH), .CNT_W(2)) dut_sat2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_r(in_r), .in_cout(in_cout), .in_opcode(in_opcode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_r(out_r2),
        .out_cout(out_cout2), .out_opcode(out_opcode2), .out_zero(out_zero2),
        .count(count2), .carry_cnt(carry_cnt2)
    );

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic [1:0] o;
    } ent_t;

    ent_t q[$];
    int   carry_ev = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_all();
        int   n;
        ent_t h;
        n = q.size();
        h = (n > 0) ? q[0] : '0;
        chk("in_ready",   32'(in_ready),   32'(n < DEPTH));
        chk("out_valid",  32'(out_valid),  32'(n > 0));
        chk("count",      32'(count),      32'(n));
        chk("out_r",      32'(out_r),      32'(h.r));
        chk("out_cout",   32'(out_cout),   32'(h.c));
        chk("out_opcode", 32'(out_opcode), 32'(h.o));
        chk("out_zero",   32'(out_zero),   32'((n > 0) && (h.r == 8'd0)));
        chk("carry_cnt",  32'(carry_cnt),  32'(sat(carry_ev, 255)));
        chk("carry_cnt2", 32'(carry_cnt2), 32'(sat(carry_ev, 3)));
        chk("count2",     32'(count2),     32'(n));
        chk("out_r2",     32'(out_r2),     32'(h.r));
        chk("in_ready2",  32'(in_ready2),  32'(n < DEPTH));
        chk("out_valid2", 32'(out_valid2), 32'(n > 0));
        chk("out_zero2",  32'(out_zero2),  32'((n > 0) && (h.r == 8'd0)));
        chk("out_misc2",  32'({out_cout2, out_opcode2}), 32'({h.c, h.o}));
    endtask

    // One clock: check current outputs, then advance the model by the edge.
    task automatic cycle();
        bit   do_push, do_pop, do_rst;
        ent_t e;
        int   n;
        check_all();
        n       = q.size();
        do_rst  = rst;
        do_push = in_valid && (n < DEPTH);
        do_pop  = out_ready && (n > 0);
        e       = '{r: in_r, c: in_cout, o: in_opcode};
        @(posedge clk);
        if (do_rst) begin
            q.delete();
            carry_ev = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(e);
                if (e.c) carry_ev++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] r, input logic c,
                         input logic [1:0] o, input logic rdy);
        in_valid  = v;
        in_r      = r;
        in_cout   = c;
        in_opcode = o;
        out_ready = rdy;
    endtask

    task automatic drain();
        drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) cycle();

        // single entry through, held then popped
        drive(1'b1, 8'h05, 1'b0, ALU_OP_SUB, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
        cycle();
        cycle();

        // fill, refused fifth push, drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0, 2'(i), 1'b0);
            cycle();
        end
        drive(1'b1, 8'h09, 1'b1, 2'd3, 1'b0);
        cycle();
        cycle();
        drain();

        // full with simultaneous push and pop: pop only, R=7 accepted later
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, 2'd1, 1'b0);
            cycle();
        end
        drive(1'b1, 8'h07, 1'b0, 2'd0, 1'b1);
        cycle();
        drive(1'b1, 8'h07, 1'b0, 2'd0, 1'b0);
        cycle();
        drain();

        // steady push+pop at occupancy 2, R=0 with carry
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h00, 1'b0, 2'd0, 1'b0);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h00, 1'b1, 2'd2, 1'b1);
            cycle();
        end
        drain();

        // reset at count 3 while pushing and popping
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b1, 2'd1, 1'b0);
            cycle();
        end
        drive(1'b1, 8'h33, 1'b1, 2'd1, 1'b1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b1, 8'h44, 1'b0, 2'd3, 1'b0);
        cycle();
        drain();

        // long random run without reset: exercises wrap and 8-bit saturation
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255) & (($urandom_range(0, 7) == 0) ? 0 : 255)),
                  $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
            cycle();
        end

        // random run with sporadic resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            cycle();
        end
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
